// File: rtl/pipelined_barrel_shifter.sv
// Logarithmic barrel shifter (SLL/SRL/SRA/ROR), one registered stage per shift-amount bit.
// Valid/ready on both ends; bubbles collapse through a combinational ready chain.
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 32,
    parameter  int TAG_W = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   shamt;
        op_e              op;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           r_stage [SHW];
    stage_t           w_next  [SHW];
    stage_t           w_in;
    logic [SHW-1:0]   w_adv;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input op_e op,
                                                  input int unsigned amt);
        logic [WIDTH-1:0] res;
        res = d;
        case (op)
            OP_SLL: res = d << amt;
            OP_SRL: res = d >> amt;
            OP_SRA: res = $signed(d) >>> amt;
            OP_ROR: res = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return res;
    endfunction

    // Stage k applies shamt bit k (shift by 2^k); a clear bit passes data through.
    function automatic stage_t stage_step(input stage_t s, input int k);
        stage_t o;
        o = s;
        if (s.shamt[k])
            o.data = shift_by(s.data, s.op, 1 << k);
        return o;
    endfunction

    always_comb begin
        w_in = '{v: in_valid, data: in_data, shamt: in_shamt, op: op_e'(in_op), tag: in_tag};
    end

    always_comb begin
        w_next[0] = stage_step(w_in, 0);
        for (int k = 1; k < SHW; k++)
            w_next[k] = stage_step(r_stage[k-1], k);
    end

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        logic w_adv_acc;
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        w_adv     = '0;
        w_adv_acc = out_ready;
        for (int k = SHW - 1; k >= 0; k--) begin
            w_adv_acc = w_adv_acc | ~r_stage[k].v;
            w_adv[k]  = w_adv_acc;
        end
    end

    // NOTE: data fields are reset too, so out_data/out_tag read zero during reset, not only valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SHW; k++)
                r_stage[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the pre-edge value of its predecessor.
            for (int k = 0; k < SHW; k++)
                if (w_adv[k])
                    r_stage[k] <= w_next[k];
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_stage[SHW-1].v;
    assign out_data  = r_stage[SHW-1].data;
    assign out_tag   = r_stage[SHW-1].tag;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32, TAG_W=4): directed table,
// handshake corner sequences, asynchronous reset and a randomised stream against a reference model.
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;
    localparam int N_RAND = 10000;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [3:0]  tag;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [16];

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Whole-amount reference shift, independent of the staged decomposition.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] op,
                                              input logic [4:0] sh);
        logic [31:0] r;
        r = d;
        case (op)
            2'd0: r = d << sh;
            2'd1: r = d >> sh;
            2'd2: r = $signed(d) >>> sh;
            default: r = (sh == 5'd0) ? d : ((d >> sh) | (d << (32 - sh)));
        endcase
        return r;
    endfunction

    task automatic drive_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                            input logic [3:0] tag);
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tag;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        int waits;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        drive_op(v.op, v.data, v.shamt, v.tag);
        #1;
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check({name, "_accept"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, 5);
        check({name, "_data"}, out_data, v.exp);
        check({name, "_tag"}, out_tag, v.tag);
    endtask

    logic [31:0] s_exp [8];
    logic [31:0] s_dat [8];
    logic [31:0] q_data [$];
    logic [3:0]  q_tag  [$];

    initial begin
        int idx;
        int got;
        int hits;
        int accepted;
        int cycles;
        logic have_op;
        logic prev_stall;
        logic [31:0] prev_data;
        logic [3:0]  prev_tag;
        logic [31:0] exp_d;
        logic [3:0]  exp_t;
        logic [1:0]  r_op;
        logic [31:0] r_d;
        logic [4:0]  r_sh;
        logic [3:0]  r_tag;

        vecs[0]  = '{2'd0, 32'h0000_0001, 5'd31, 4'd3,  32'h8000_0000};
        vecs[1]  = '{2'd2, 32'h8000_0000, 5'd4,  4'd1,  32'hF800_0000};
        vecs[2]  = '{2'd1, 32'h8000_0000, 5'd4,  4'd2,  32'h0800_0000};
        vecs[3]  = '{2'd3, 32'h0000_00F1, 5'd4,  4'd4,  32'h1000_000F};
        vecs[4]  = '{2'd0, 32'hA5A5_A5A5, 5'd0,  4'd5,  32'hA5A5_A5A5};
        vecs[5]  = '{2'd1, 32'hA5A5_A5A5, 5'd0,  4'd6,  32'hA5A5_A5A5};
        vecs[6]  = '{2'd2, 32'hA5A5_A5A5, 5'd0,  4'd7,  32'hA5A5_A5A5};
        vecs[7]  = '{2'd3, 32'hA5A5_A5A5, 5'd0,  4'd8,  32'hA5A5_A5A5};
        vecs[8]  = '{2'd0, 32'h1234_5678, 5'd8,  4'd9,  32'h3456_7800};
        vecs[9]  = '{2'd2, 32'h7FFF_0000, 5'd16, 4'd10, 32'h0000_7FFF};
        vecs[10] = '{2'd2, 32'h8000_0001, 5'd31, 4'd11, 32'hFFFF_FFFF};
        vecs[11] = '{2'd1, 32'hFFFF_FFFF, 5'd31, 4'd12, 32'h0000_0001};
        vecs[12] = '{2'd3, 32'h1234_5678, 5'd31, 4'd13, 32'h2468_ACF0};
        vecs[13] = '{2'd3, 32'h8000_0001, 5'd1,  4'd14, 32'hC000_0000};
        vecs[14] = '{2'd0, 32'hDEAD_BEEF, 5'd16, 4'd15, 32'hBEEF_0000};
        vecs[15] = '{2'd2, 32'hC000_0000, 5'd5,  4'd0,  32'hFE00_0000};

        // Reset state
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_op(2'd0, 32'h0, 5'd0, 4'd0);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 32'h0);
        check("reset_out_tag", out_tag, 4'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_in_ready", in_ready, 1'b1);
        check("post_reset_out_valid", out_valid, 1'b0);

        // Directed table, one op at a time
        for (int i = 0; i < 16; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back SRA then SRL must emerge on consecutive cycles
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive_op(2'd2, 32'h8000_0000, 5'd4, 4'd5);
        #1;
        check("b2b_accept0", in_ready, 1'b1);
        @(negedge clk);
        drive_op(2'd1, 32'h8000_0000, 5'd4, 4'd6);
        #1;
        check("b2b_accept1", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        got = 0;
        while (!out_valid && got < 20) begin
            @(negedge clk);
            #1;
            got++;
        end
        check("b2b_first_data", out_data, 32'hF800_0000);
        check("b2b_first_tag", out_tag, 4'd5);
        @(negedge clk);
        #1;
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_data", out_data, 32'h0800_0000);
        check("b2b_second_tag", out_tag, 4'd6);

        // Fill with out_ready low, then drain
        for (int i = 0; i < 8; i++) begin
            s_dat[i] = 32'h0101_0101 * (i + 1);
            s_exp[i] = ref_shift(s_dat[i], 2'(i % 4), 5'(i * 3 + 1));
        end
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            drive_op(2'(idx % 4), s_dat[idx], 5'(idx * 3 + 1), 4'(idx));
            #1;
            if (out_valid) begin
                check("stall_hold_tag", out_tag, 4'd0);
                check("stall_hold_data", out_data, s_exp[0]);
            end
            if (in_ready)
                idx++;
        end
        check("stall_accept_count", idx, 5);
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);

        got = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (idx < 8);
            if (idx < 8)
                drive_op(2'(idx % 4), s_dat[idx], 5'(idx * 3 + 1), 4'(idx));
            #1;
            if (out_valid) begin
                check($sformatf("drain%0d_tag", got), out_tag, 4'(got));
                check($sformatf("drain%0d_data", got), out_data, s_exp[got]);
                got++;
            end else if (got > 0) begin
                check("drain_gap", out_valid, 1'b1);
            end
            if (in_valid && in_ready)
                idx++;
        end
        check("drain_count", got, 8);

        // Asynchronous reset with three ops in flight
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (c < 3);
            drive_op(2'd0, 32'h0000_0F0F, 5'd2, 4'(9 + c));
            #1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("rst_pre_out_valid", out_valid, 1'b1);
        check("rst_pre_out_tag", out_tag, 4'd9);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 1'b0);
        check("rst_async_out_data", out_data, 32'h0);
        check("rst_async_out_tag", out_tag, 4'h0);
        @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);
        hits = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            if (out_valid)
                hits++;
        end
        check("rst_no_ghost_outputs", hits, 0);

        // Randomised stream against the reference model
        accepted   = 0;
        cycles     = 0;
        have_op    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_tag   = '0;
        r_op = '0; r_d = '0; r_sh = '0; r_tag = '0;
        while ((accepted < N_RAND || q_data.size() > 0) && cycles < 80000) begin
            @(negedge clk);
            if (accepted < N_RAND) begin
                if (!have_op) begin
                    r_op    = 2'($urandom_range(0, 3));
                    r_d     = $urandom();
                    r_sh    = 5'($urandom_range(0, 31));
                    r_tag   = 4'($urandom_range(0, 15));
                    have_op = 1'b1;
                end
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                drive_op(r_op, r_d, r_sh, r_tag);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (prev_stall)
                check("rand_hold", {out_valid, out_data, out_tag}, {1'b1, prev_data, prev_tag});
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) begin
                    check("rand_spurious", out_valid, 1'b0);
                end else begin
                    exp_d = q_data.pop_front();
                    exp_t = q_tag.pop_front();
                    check("rand_result", {out_data, out_tag}, {exp_d, exp_t});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
            if (in_valid && in_ready) begin
                q_data.push_back(ref_shift(r_d, r_op, r_sh));
                q_tag.push_back(r_tag);
                accepted++;
                have_op = 1'b0;
            end
            cycles++;
        end
        check("rand_accepted", accepted, N_RAND);
        check("rand_queue_empty", q_data.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
